// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants used by the fetch top, its IF/ID
// register and the fetch bus interface.
package instr_fetch_pkg;

   localparam int          INST_W           = 32;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

   // Word-align a byte address by clearing the two low bits.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and
// the IF/ID handshake towards decode. The fetch stage is the master.
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic              imem_req;
   logic [31:0]       imem_addr;
   logic              imem_rvalid;
   logic [INST_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              id_ready;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [31:0]       inst_pc;
   logic [31:0]       pc_plus4;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4,
      input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc_plus4,
      output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// Single-entry IF/ID register: loads a fetched word, holds it while decode
// stalls, drops it when decode takes it or when the fetch path is flushed.
module instr_fetch_if_id_reg
   import instr_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              load,
   input  logic [INST_W-1:0] load_inst,
   input  logic [31:0]       load_pc,
   input  logic              id_ready,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [31:0]       inst_pc,
   output logic [31:0]       pc_plus4
);

   logic              valid_r;
   logic [INST_W-1:0] inst_r;
   logic [31:0]       inst_pc_r;
   logic [31:0]       pc_plus4_r;

   // Entry state: flush wins, then a new load, then consumption by decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r    <= 1'b0;
         inst_r     <= {INST_W{1'b0}};
         inst_pc_r  <= 32'h0000_0000;
         pc_plus4_r <= 32'h0000_0000;
      end else begin
         if (flush) begin
            valid_r <= 1'b0;
         end else if (load) begin
            valid_r <= 1'b1;
         end else if (valid_r && id_ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
         // Payload only changes on a load, so it is stable across stalls.
         if (load) begin
            inst_r     <= load_inst;
            inst_pc_r  <= load_pc;
            pc_plus4_r <= load_pc + PC_INC;
         end
      end
   end

   assign inst_valid = valid_r;
   assign inst       = inst_r;
   assign inst_pc    = inst_pc_r;
   assign pc_plus4   = pc_plus4_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// forwards returned words to decode through the IF/ID register. Redirects
// retarget the PC and squash any in-flight wrong-path response.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   fetch_state_e state_r;
   logic [31:0]  pc_r;
   logic         free_s;
   logic         req_s;
   logic         load_s;

   // Slot availability, request issue and response capture decisions.
   always_comb begin
      free_s = 1'b0;
      req_s  = 1'b0;
      load_s = 1'b0;
      if (!bus.inst_valid || bus.id_ready) begin
         free_s = 1'b1;
      end else begin
         free_s = 1'b0;
      end
      // Masked by rst so memory never sees a request while reset is held.
      if (rst && (state_r == ISSUE) && !bus.redirect_valid && free_s) begin
         req_s = 1'b1;
      end else begin
         req_s = 1'b0;
      end
      if ((state_r == WAIT) && bus.imem_rvalid && !bus.redirect_valid) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   assign bus.imem_req  = req_s;
   assign bus.imem_addr = req_s ? pc_r : 32'h0000_0000;

   // Fetch sequencer: tracks the outstanding request and steers the PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ISSUE;
         pc_r    <= RESET_PC;
      end else begin
         case (state_r)
            ISSUE: begin
               if (bus.redirect_valid) begin
                  pc_r <= align_pc(bus.redirect_pc);
               end else if (req_s) begin
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               if (bus.redirect_valid) begin
                  pc_r    <= align_pc(bus.redirect_pc);
                  state_r <= bus.imem_rvalid ? ISSUE : DROP;
               end else if (bus.imem_rvalid) begin
                  pc_r    <= pc_r + PC_INC;
                  state_r <= ISSUE;
               end
            end
            DROP: begin
               if (bus.redirect_valid) begin
                  pc_r <= align_pc(bus.redirect_pc);
               end
               if (bus.imem_rvalid) begin
                  state_r <= ISSUE;
               end
            end
            default: begin
               state_r <= ISSUE;
            end
         endcase
      end
   end

   instr_fetch_if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.redirect_valid),
      .load       (load_s),
      .load_inst  (bus.imem_rdata),
      .load_pc    (pc_r),
      .id_ready   (bus.id_ready),
      .inst_valid (bus.inst_valid),
      .inst       (bus.inst),
      .inst_pc    (bus.inst_pc),
      .pc_plus4   (bus.pc_plus4)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// phase, checked against a transaction-level reference model of the stage.
module tb_instr_fetch;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   instr_fetch_if bus_a ();
   instr_fetch_if bus_b ();

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: next fetch address, in-flight request, whether that
   // request has been abandoned by a redirect, and the IF/ID entry.
   logic [31:0] m_pc;
   logic        m_busy;
   logic        m_stale;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_ipc;

   // Memory model: one pending response with a countdown.
   logic        mem_pend;
   int          mem_cnt;
   int          mem_lat;
   logic [31:0] mem_addr;

   logic        last_req;
   logic [31:0] last_addr;
   int          cyc;
   int          req_cyc[$];
   logic [31:0] req_adr[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h2001_0005;
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h1F0F};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic zero_check(input string who, input logic req, input logic [31:0] addr,
                             input logic v, input logic [31:0] i, input logic [31:0] ip,
                             input logic [31:0] p4);
      chk({who, "_imem_req"},   {31'd0, req}, 32'd0);
      chk({who, "_imem_addr"},  addr, 32'd0);
      chk({who, "_inst_valid"}, {31'd0, v}, 32'd0);
      chk({who, "_inst"},       i, 32'd0);
      chk({who, "_inst_pc"},    ip, 32'd0);
      chk({who, "_pc_plus4"},   p4, 32'd0);
   endtask

   task automatic quiet_inputs();
      bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = 32'd0; bus_a.id_ready = 1'b0;
      bus_a.imem_rvalid = 1'b0;    bus_a.imem_rdata = 32'd0;
      bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 32'd0; bus_b.id_ready = 1'b0;
      bus_b.imem_rvalid = 1'b0;    bus_b.imem_rdata = 32'd0;
   endtask

   // Entered and left at a falling clock edge; reset is released there.
   task automatic reset_phase();
      rst = 1'b0;
      quiet_inputs();
      m_pc = 32'd0; m_busy = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
      m_inst = 32'd0; m_ipc = 32'd0;
      mem_pend = 1'b0; mem_cnt = 0;
      #1;
      zero_check("rst_a", bus_a.imem_req, bus_a.imem_addr, bus_a.inst_valid,
                 bus_a.inst, bus_a.inst_pc, bus_a.pc_plus4);
      zero_check("rst_b", bus_b.imem_req, bus_b.imem_addr, bus_b.inst_valid,
                 bus_b.inst, bus_b.inst_pc, bus_b.pc_plus4);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock of dut_a: drive inputs, check against model, advance model.
   task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy);
      logic        rv;
      logic        exp_req;
      logic        transfer;
      logic [31:0] rdata;
      bus_a.redirect_valid = redir;
      bus_a.redirect_pc    = tgt;
      bus_a.id_ready       = rdy;
      rv    = 1'b0;
      rdata = 32'hDEAD_BEEF;
      if (mem_pend) begin
         if (mem_cnt <= 1) begin
            rv = 1'b1; rdata = mem_word(mem_addr); mem_pend = 1'b0;
         end else begin
            mem_cnt = mem_cnt - 1;
         end
      end
      bus_a.imem_rvalid = rv;
      bus_a.imem_rdata  = rdata;
      #1;
      exp_req = !m_busy && !redir && (!m_valid || rdy);
      chk("imem_req", {31'd0, bus_a.imem_req}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", bus_a.imem_addr, m_pc);
      chk("inst_valid", {31'd0, bus_a.inst_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("inst", bus_a.inst, m_inst);
         chk("inst_pc", bus_a.inst_pc, m_ipc);
         chk("pc_plus4", bus_a.pc_plus4, m_ipc + 32'd4);
      end
      last_req  = bus_a.imem_req;
      last_addr = bus_a.imem_addr;
      if (bus_a.imem_req) begin
         mem_pend = 1'b1; mem_cnt = mem_lat; mem_addr = bus_a.imem_addr;
         req_cyc.push_back(cyc);
         req_adr.push_back(bus_a.imem_addr);
      end
      transfer = m_valid && rdy;
      if (redir || transfer) m_valid = 1'b0;
      if (m_busy && rv) begin
         if (!m_stale && !redir) begin
            m_valid = 1'b1; m_inst = rdata; m_ipc = m_pc; m_pc = m_pc + 32'd4;
         end
         m_busy = 1'b0; m_stale = 1'b0;
      end else if (m_busy && redir) begin
         m_stale = 1'b1;
      end
      if (redir) m_pc = {tgt[31:2], 2'b00};
      if (exp_req) begin
         m_busy = 1'b1; m_stale = 1'b0;
      end
      cyc++;
      @(negedge clk);
   endtask

   logic [31:0] b_req [0:3];
   logic        b_pend;
   logic [31:0] b_addr;
   int          nb;
   int          nreq;
   logic        got_first;
   logic        saw_valid;
   logic [31:0] b_ipc;
   logic [31:0] b_p4;
   logic [31:0] b_inst;

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0;
      mem_lat = 1; cyc = 0;
      last_req = 1'b0; last_addr = 32'd0;
      quiet_inputs();
      @(negedge clk);
      reset_phase();

      // 1: zero-wait memory, decode always ready.
      req_cyc.delete(); req_adr.delete();
      cycle(1'b0, 32'd0, 1'b1);
      cycle(1'b0, 32'd0, 1'b1);
      chk("t1_first_valid", {31'd0, bus_a.inst_valid}, 32'd1);
      chk("t1_first_inst", bus_a.inst, 32'h2001_0005);
      chk("t1_first_pc", bus_a.inst_pc, 32'h0);
      chk("t1_first_p4", bus_a.pc_plus4, 32'h4);
      for (int k = 0; k < 6; k++) cycle(1'b0, 32'd0, 1'b1);
      chk("t1_nreq", 32'(req_adr.size()), 32'd4);
      if (req_adr.size() >= 4) begin
         for (int k = 0; k < 4; k++) chk("t1_addr", req_adr[k], 32'(k * 4));
         for (int k = 1; k < 4; k++) chk("t1_gap", 32'(req_cyc[k] - req_cyc[k-1]), 32'd2);
      end

      // 2: decode stalls for five cycles with an entry held.
      nreq = 0;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 32'd0, 1'b0);
         nreq += int'(last_req);
      end
      chk("t2_noreq", 32'(nreq), 32'd0);
      chk("t2_hold_inst", bus_a.inst, mem_word(32'hC));
      chk("t2_hold_pc", bus_a.inst_pc, 32'hC);
      mem_lat = 3;
      cycle(1'b0, 32'd0, 1'b1);
      chk("t2_resume_req", {31'd0, last_req}, 32'd1);
      chk("t2_resume_addr", last_addr, 32'h10);

      // 3: redirect while waiting on a slow response.
      cycle(1'b1, 32'h0000_0103, 1'b1);
      mem_lat = 1;
      saw_valid = 1'b0;
      for (int k = 0; k < 10 && !last_req; k++) begin
         cycle(1'b0, 32'd0, 1'b1);
         saw_valid |= bus_a.inst_valid;
      end
      chk("t3_req_seen", {31'd0, last_req}, 32'd1);
      chk("t3_addr", last_addr, 32'h100);
      chk("t3_no_wrong_path", {31'd0, saw_valid}, 32'd0);

      // 4: redirect coincides with the response.
      cycle(1'b1, 32'h0000_0200, 1'b1);
      chk("t4_valid", {31'd0, bus_a.inst_valid}, 32'd0);
      cycle(1'b0, 32'd0, 1'b1);
      chk("t4_req", {31'd0, last_req}, 32'd1);
      chk("t4_addr", last_addr, 32'h200);

      // 5: redirect flushes a stalled entry.
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      chk("t5_pre_valid", {31'd0, bus_a.inst_valid}, 32'd1);
      cycle(1'b1, 32'h0000_0300, 1'b0);
      chk("t5_flush", {31'd0, bus_a.inst_valid}, 32'd0);

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         mem_lat = $urandom_range(1, 4);
         cycle(($urandom_range(0, 9) == 0), $urandom(), ($urandom_range(0, 3) != 0));
      end

      // 6: wrap-around reset PC on dut_b, then reset asserted mid-request.
      reset_phase();
      b_pend = 1'b0; b_addr = 32'd0; nb = 0; got_first = 1'b0;
      b_ipc = 32'd0; b_p4 = 32'd0; b_inst = 32'd0;
      for (int k = 0; k < 4; k++) b_req[k] = 32'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) begin
         bus_b.id_ready       = 1'b1;
         bus_b.redirect_valid = 1'b0;
         bus_b.imem_rvalid    = b_pend;
         bus_b.imem_rdata     = b_pend ? mem_word(b_addr) : 32'd0;
         #1;
         b_pend = bus_b.imem_req;
         if (bus_b.imem_req) begin
            if (nb < 4) b_req[nb] = bus_b.imem_addr;
            nb++;
            b_addr = bus_b.imem_addr;
         end
         @(negedge clk);
         if (bus_b.inst_valid && !got_first) begin
            got_first = 1'b1;
            b_ipc = bus_b.inst_pc; b_p4 = bus_b.pc_plus4; b_inst = bus_b.inst;
         end
      end
      chk("t6_nreq", 32'(nb), 32'd3);
      chk("t6_req0", b_req[0], 32'hFFFF_FFFC);
      chk("t6_req1", b_req[1], 32'h0000_0000);
      chk("t6_got_first", {31'd0, got_first}, 32'd1);
      chk("t6_inst_pc", b_ipc, 32'hFFFF_FFFC);
      chk("t6_pc_plus4", b_p4, 32'h0000_0000);
      chk("t6_inst", b_inst, mem_word(32'hFFFF_FFFC));
      #2;
      rst = 1'b0;
      #1;
      zero_check("midwait_b", bus_b.imem_req, bus_b.imem_addr, bus_b.inst_valid,
                 bus_b.inst, bus_b.inst_pc, bus_b.pc_plus4);
      zero_check("midwait_a", bus_a.imem_req, bus_a.imem_addr, bus_a.inst_valid,
                 bus_a.inst, bus_a.inst_pc, bus_a.pc_plus4);
      @(negedge clk);
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
